// File: rtl/scr1_dmem_router.sv
// scr1_dmem_router: routes LSU data-memory requests to port 0 (TCM/default)
// or port 1 (address-matched). Optional timeout/drain: SCR1_DMEM_RTR_TOUT_EN.

`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

package scr1_dmem_router_pkg;
  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;
endpackage

module scr1_dmem_router
  import scr1_dmem_router_pkg::*;
#(
  parameter logic [`SCR1_DMEM_AWIDTH-1:0] PORT1_BASE = 32'hF000_0000,
  parameter logic [`SCR1_DMEM_AWIDTH-1:0] PORT1_MASK = 32'hFFFF_0000,
  parameter logic [7:0] TOUT_CYCLES = 8'd255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         lsu_req,
  input  type_scr1_mem_cmd_e           lsu_cmd,
  input  type_scr1_mem_width_e         lsu_width,
  input  logic [`SCR1_DMEM_AWIDTH-1:0] lsu_addr,
  input  logic [`SCR1_DMEM_DWIDTH-1:0] lsu_wdata,
  output logic                         lsu_req_ack,
  output logic [`SCR1_DMEM_DWIDTH-1:0] lsu_rdata,
  output type_scr1_mem_resp_e          lsu_resp,
  output logic                         port0_req,
  output type_scr1_mem_cmd_e           port0_cmd,
  output type_scr1_mem_width_e         port0_width,
  output logic [`SCR1_DMEM_AWIDTH-1:0] port0_addr,
  output logic [`SCR1_DMEM_DWIDTH-1:0] port0_wdata,
  input  logic                         port0_req_ack,
  input  logic [`SCR1_DMEM_DWIDTH-1:0] port0_rdata,
  input  type_scr1_mem_resp_e          port0_resp,
  output logic                         port1_req,
  output type_scr1_mem_cmd_e           port1_cmd,
  output type_scr1_mem_width_e         port1_width,
  output logic [`SCR1_DMEM_AWIDTH-1:0] port1_addr,
  output logic [`SCR1_DMEM_DWIDTH-1:0] port1_wdata,
  input  logic                         port1_req_ack,
  input  logic [`SCR1_DMEM_DWIDTH-1:0] port1_rdata,
  input  type_scr1_mem_resp_e          port1_resp
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
`ifdef SCR1_DMEM_RTR_TOUT_EN
    ST_DRAIN = 2'd2,
`endif
    ST_WAIT  = 2'd1
  } fsm_e;

  fsm_e                         fsm_q;
  fsm_e                         fsm_d;
  logic                         sel_q;
  logic                         sel_d;
  logic                         sel_nxt;
  logic                         tgt_ack;
  logic                         fwd_en;
  logic                         resp_rdy;
  logic                         resp_done;
  type_scr1_mem_resp_e          sel_resp;
  logic [`SCR1_DMEM_DWIDTH-1:0] sel_rdata;

  assign port0_cmd   = lsu_cmd;
  assign port0_width = lsu_width;
  assign port0_addr  = lsu_addr;
  assign port0_wdata = lsu_wdata;
  assign port1_cmd   = lsu_cmd;
  assign port1_width = lsu_width;
  assign port1_addr  = lsu_addr;
  assign port1_wdata = lsu_wdata;

  // Address decode and response mux of the port owning the transaction
  always_comb begin
    sel_nxt   = ((lsu_addr & PORT1_MASK) == PORT1_BASE);
    tgt_ack   = sel_nxt ? port1_req_ack : port0_req_ack;
    sel_resp  = sel_q ? port1_resp : port0_resp;
    sel_rdata = sel_q ? port1_rdata : port0_rdata;
    resp_rdy  = (sel_resp == SCR1_MEM_RESP_RDY_OK)
              | (sel_resp == SCR1_MEM_RESP_RDY_ER);
    resp_done = (fsm_q == ST_WAIT) & resp_rdy;
    fwd_en    = (fsm_q == ST_IDLE) | resp_done;
  end

`ifdef SCR1_DMEM_RTR_TOUT_EN
  logic [7:0] tout_cnt_q;
  logic [7:0] tout_cnt_d;
  logic       tout_hit;

  assign tout_hit = (fsm_q == ST_WAIT) & ~resp_rdy
                  & (tout_cnt_q == (TOUT_CYCLES - 8'd1));

  // Count WAIT cycles of the current transaction, restart on each new one
  always_comb begin
    tout_cnt_d = tout_cnt_q;
    if ((fsm_d == ST_WAIT) & ((fsm_q != ST_WAIT) | resp_done)) begin
      tout_cnt_d = 8'd0;
    end else if ((fsm_q == ST_WAIT) & ~resp_done) begin
      tout_cnt_d = tout_cnt_q + 8'd1;
    end
  end

  // Timeout counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      tout_cnt_q <= 8'd0;
    end else begin
      tout_cnt_q <= tout_cnt_d;
    end
  end
`else
  logic unused_tout;
  assign unused_tout = ^TOUT_CYCLES;
`endif

  // Request gating, response return and next-state logic
  always_comb begin
    lsu_req_ack = lsu_req & fwd_en & tgt_ack;
    port0_req   = lsu_req & fwd_en & ~sel_nxt;
    port1_req   = lsu_req & fwd_en & sel_nxt;
    lsu_resp    = SCR1_MEM_RESP_NOTRDY;
    lsu_rdata   = '0;
    fsm_d       = fsm_q;
    sel_d       = sel_q;
    case (fsm_q)
      ST_IDLE: begin
        if (lsu_req_ack) begin
          sel_d = sel_nxt;
          fsm_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        lsu_resp = sel_resp;
        if (sel_resp == SCR1_MEM_RESP_RDY_OK) begin
          lsu_rdata = sel_rdata;
        end
        if (resp_done) begin
          if (lsu_req_ack) begin
            sel_d = sel_nxt;
          end else begin
            fsm_d = ST_IDLE;
          end
        end
`ifdef SCR1_DMEM_RTR_TOUT_EN
        else if (tout_hit) begin
          lsu_resp = SCR1_MEM_RESP_RDY_ER;
          fsm_d    = ST_DRAIN;
        end
`endif
      end
`ifdef SCR1_DMEM_RTR_TOUT_EN
      ST_DRAIN: begin
        if (resp_rdy) begin
          fsm_d = ST_IDLE;
        end
      end
`endif
      default: begin
        fsm_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and owning-port register
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= ST_IDLE;
      sel_q <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      sel_q <= sel_d;
    end
  end

`ifdef SCR1_TRGT_SIMULATION
  // Flag responses from a port that owns no outstanding transaction
  always @(posedge clk) begin
    if (!rst) begin
      assert ((port0_resp == SCR1_MEM_RESP_NOTRDY)
              || ((fsm_q != ST_IDLE) && !sel_q))
        else $warning("dmem_router: unexpected port0 response");
      assert ((port1_resp == SCR1_MEM_RESP_NOTRDY)
              || ((fsm_q != ST_IDLE) && sel_q))
        else $warning("dmem_router: unexpected port1 response");
    end
  end
`endif

endmodule

// File: doc/scr1_dmem_router.md
Name: scr1_dmem_router

Overview:
- Sits directly downstream of the LSU, between its data-memory request port and two data-memory targets.
- Port 0 is the TCM/default target; port 1 is the address-matched target, e.g. the external bus or MMIO.
- Decodes each LSU request address and forwards the request to exactly one target.
- Tracks the single outstanding transaction and returns the owning target's response and read data to the LSU.
- Supports back-to-back requests: a new request may be issued in the same cycle the previous response is delivered.

Parameters:
- PORT1_BASE, 32'hF000_0000, base address of the port-1 region.
- PORT1_MASK, 32'hFFFF_0000, decode mask; the request goes to port 1 when (addr & PORT1_MASK) == PORT1_BASE.
- TOUT_CYCLES, 8'd255, response timeout in cycles. Used only with SCR1_DMEM_RTR_TOUT_EN; must be >= 1.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high
- lsu_req  in  1  request from LSU
- lsu_cmd  in  type_scr1_mem_cmd_e  RD/WR
- lsu_width  in  type_scr1_mem_width_e  BYTE/HWORD/WORD
- lsu_addr  in  `SCR1_DMEM_AWIDTH  request address
- lsu_wdata  in  `SCR1_DMEM_DWIDTH  store data
- lsu_req_ack  out  1  request accepted
- lsu_rdata  out  `SCR1_DMEM_DWIDTH  load data
- lsu_resp  out  type_scr1_mem_resp_e  NOTRDY/RDY_OK/RDY_ER
- port0_req, port1_req  out  1  target request
- port0_cmd, port1_cmd  out  type_scr1_mem_cmd_e  forwarded cmd
- port0_width, port1_width  out  type_scr1_mem_width_e  forwarded width
- port0_addr, port1_addr  out  `SCR1_DMEM_AWIDTH  forwarded address
- port0_wdata, port1_wdata  out  `SCR1_DMEM_DWIDTH  forwarded store data
- port0_req_ack, port1_req_ack  in  1  target accept
- port0_rdata, port1_rdata  in  `SCR1_DMEM_DWIDTH  target read data
- port0_resp, port1_resp  in  type_scr1_mem_resp_e  target response

Behaviour:
- Decode (combinational): sel_nxt = ((lsu_addr & PORT1_MASK) == PORT1_BASE).
- cmd, width, addr and wdata are driven to both ports unconditionally; only the req is gated.
- State register fsm has states IDLE and WAIT (plus DRAIN with the optional feature). Also registered: sel_r (1 bit), and tout_cnt when the option is enabled.
- Reset (rst=1 at posedge): fsm=IDLE, sel_r=0, tout_cnt=0.
  - Combinational outputs in IDLE with lsu_req=0: portX_req=0, lsu_req_ack=0, lsu_resp=NOTRDY, lsu_rdata=0.
- resp_done = (fsm==WAIT) & (resp of port sel_r is RDY_OK or RDY_ER).
- Forwarding enable: fwd_en = (fsm==IDLE) | resp_done.
  - portX_req = lsu_req & fwd_en & (sel_nxt==X).
  - lsu_req_ack = ack of port sel_nxt, gated by lsu_req & fwd_en.
- IDLE:
  - lsu_resp=NOTRDY, lsu_rdata=0.
  - On lsu_req & lsu_req_ack: sel_r<=sel_nxt, fsm<=WAIT.
  - A request that is not acked stays pending; the target port is unchanged while lsu_req is held.
- WAIT:
  - lsu_resp and lsu_rdata are muxed combinationally from port sel_r (zero added latency).
  - lsu_rdata=0 unless lsu_resp==RDY_OK.
  - On resp_done with a new lsu_req acked in the same cycle: sel_r<=sel_nxt, stay WAIT.
  - On resp_done without a new acked request: fsm<=IDLE.
  - Otherwise hold.
- Responses from the non-selected port, and any response in IDLE, are ignored (not forwarded). The simulation assertion flags them as unexpected.
- Response of RDY_ER is forwarded unchanged; the LSU raises the access fault.
- Reset mid-transaction: the outstanding transaction is abandoned. A late target response after reset is ignored in IDLE.
- At most one outstanding transaction at any time.
- lsu_req_ack is never asserted while fsm==WAIT and the response has not yet arrived.

Optional Feature:
- Macro: SCR1_DMEM_RTR_TOUT_EN.
- Enabled:
  - tout_cnt clears on entry to WAIT and increments each WAIT cycle without resp_done.
  - When tout_cnt==TOUT_CYCLES-1 and still no response: lsu_resp=RDY_ER (lsu_rdata=0) for that one cycle, fsm<=DRAIN. No new request is forwarded that cycle.
  - DRAIN: fwd_en=0 and lsu_resp=NOTRDY. On RDY_OK/RDY_ER from port sel_r, the response is swallowed and fsm<=IDLE.
  - Reset exits DRAIN to IDLE.
- Disabled: no counter and no DRAIN state; WAIT waits indefinitely.

Test Plan:
- Read to addr 0x0000_0100, port0 acks in cycle 0 and returns RDY_OK with rdata 0xDEADBEEF in cycle 2 -> port1_req never asserted; lsu_resp RDY_OK and lsu_rdata 0xDEADBEEF in cycle 2; fsm IDLE in cycle 3.
- Write to 0xF000_0010 with width WORD and wdata 0x12345678 -> only port1_req=1, port1_wdata=0x12345678; port1 RDY_ER returns lsu_resp RDY_ER.
- Back-to-back: port0 read responds in the same cycle a port1 read to 0xF000_0004 is presented -> port1_req=1 and lsu_req_ack=1 that cycle; sel_r=1 and next response taken from port1.
- Stray port1 RDY_OK while waiting on port0, then port0 RDY_OK -> stray response not forwarded; lsu_resp RDY_OK exactly once, with port0 data.
- rst=1 during WAIT, then late port0 RDY_OK -> outputs at reset values; lsu_resp stays NOTRDY.
- With SCR1_DMEM_RTR_TOUT_EN and TOUT_CYCLES=4, port0 silent for 10 cycles then responds:
  - lsu_resp RDY_ER on the 4th WAIT cycle.
  - Requests are not acked during DRAIN.
  - The late response is swallowed, then fsm returns to IDLE.
